// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: result-source select, access size and FSM states.
package mem_pkg;

  localparam logic [2:0] RES_ALU  = 3'b000;
  localparam logic [2:0] RES_LOAD = 3'b001;
  localparam logic [2:0] RES_PC4  = 3'b010;
  localparam logic [2:0] RES_IMM  = 3'b011;
  localparam logic [2:0] RES_PCT  = 3'b100;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane alignment: store data/strobe shifting, load shift and extension, misalign check.
// Misalign detection is active only when MISALIGN_TRAP_EN is defined; otherwise misaligned is 0.
module load_store_align
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [2:0]              off,
  input  logic [1:0]              size,
  input  logic                    unsigned_ld,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [DATA_WIDTH-1:0]   rdata,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic                    misaligned
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [5:0]            lane_sh;
  logic [STRB_W-1:0]     base_strb;
  logic [DATA_WIDTH-1:0] shifted;

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] v,
                                                   input logic [1:0] sz,
                                                   input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = v[7:0];
    h = v[15:0];
    w = v[31:0];
    case (sz)
      SZ_B:    if (uns) extend = {{(DATA_WIDTH-8){1'b0}}, v[7:0]};
               else     extend = DATA_WIDTH'(b);
      SZ_H:    if (uns) extend = {{(DATA_WIDTH-16){1'b0}}, v[15:0]};
               else     extend = DATA_WIDTH'(h);
      SZ_W:    if (uns) extend = {{(DATA_WIDTH-32){1'b0}}, v[31:0]};
               else     extend = DATA_WIDTH'(w);
      default: extend = v;
    endcase
  endfunction

  assign lane_sh = {off, 3'b000};

  always_comb begin
    case (size)
      SZ_B:    base_strb = STRB_W'(8'h01);
      SZ_H:    base_strb = STRB_W'(8'h03);
      SZ_W:    base_strb = STRB_W'(8'h0F);
      default: base_strb = STRB_W'(8'hFF);
    endcase
  end

  // Bytes pushed past the top lane are simply dropped by the fixed-width shifts.
  assign wdata     = store_data << lane_sh;
  assign wstrb     = base_strb << off;
  assign shifted   = rdata >> lane_sh;
  assign load_data = extend(shifted, size, unsigned_ld);

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: issues load/store over a valid/ready port, stalls upstream, registers the WB result.
// MISALIGN_TRAP_EN enables suppression of misaligned accesses and the o_misaligned flag.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  logic [2:0]              i_result_src,
  input  logic                    i_mem_we,
  input  logic                    i_reg_we,
  input  logic [2:0]              i_func3,
  input  logic [ADDR_WIDTH-1:0]   i_pc_plus4,
  input  logic [ADDR_WIDTH-1:0]   i_pc_target,
  input  logic [DATA_WIDTH-1:0]   i_imm_ext,
  input  logic [DATA_WIDTH-1:0]   i_alu_result,
  input  logic [DATA_WIDTH-1:0]   i_write_data,
  input  logic [REG_ADDR_W-1:0]   i_rd_addr,
  output logic                    o_mem_req_valid,
  input  logic                    i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_we,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
  input  logic                    i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_stall,
  output logic [DATA_WIDTH-1:0]   o_result,
  output logic [REG_ADDR_W-1:0]   o_rd_addr,
  output logic                    o_reg_we,
  output logic                    o_misaligned
);

  state_t state, state_n;

  logic                    is_store, is_load, mem_op, trap, misaligned;
  logic                    req_valid, done, stall;
  logic [DATA_WIDTH-1:0]   load_data, sel_result;
  logic [DATA_WIDTH-1:0]   result_p1;
  logic [REG_ADDR_W-1:0]   rd_p1;
  logic                    vld_p1;

  assign is_store = i_mem_we;
  assign is_load  = !i_mem_we && (i_result_src == RES_LOAD);
  assign mem_op   = is_store || is_load;
  assign trap     = mem_op && misaligned;

  load_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .off        (i_alu_result[2:0]),
    .size       (i_func3[1:0]),
    .unsigned_ld(i_func3[2]),
    .store_data (i_write_data),
    .rdata      (i_mem_rdata),
    .wdata      (o_mem_wdata),
    .wstrb      (o_mem_wstrb),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  always_comb begin
    case (i_result_src)
      RES_LOAD: sel_result = load_data;
      RES_PC4:  sel_result = DATA_WIDTH'(i_pc_plus4);
      RES_IMM:  sel_result = i_imm_ext;
      RES_PCT:  sel_result = DATA_WIDTH'(i_pc_target);
      default:  sel_result = i_alu_result;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state <= IDLE;
    else        state <= state_n;
  end

  // done marks the completion cycle: store accepted or load data returned.
  always_comb begin
    state_n   = state;
    req_valid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !trap) begin
          req_valid = 1'b1;
          if (!i_mem_req_ready) state_n = REQ;
          else if (is_store)    done    = 1'b1;
          else                  state_n = RESP;
        end
      end
      REQ: begin
        req_valid = 1'b1;
        if (i_mem_req_ready) begin
          if (is_store) begin
            done    = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = RESP;
          end
        end
      end
      RESP: begin
        if (i_mem_rvalid) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign stall           = mem_op && !trap && !done;
  assign o_stall         = !i_arst && stall;
  assign o_mem_req_valid = !i_arst && req_valid;
  assign o_mem_we        = o_mem_req_valid && is_store;
  assign o_mem_addr      = {i_alu_result[ADDR_WIDTH-1:3], 3'b000};

  // ---- stage p1: memory/writeback pipeline register ----
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      result_p1 <= '0;
      rd_p1     <= '0;
      vld_p1    <= 1'b0;
    end else if (stall || trap || is_store) begin
      vld_p1 <= 1'b0;
    end else begin
      result_p1 <= sel_result;
      rd_p1     <= i_rd_addr;
      vld_p1    <= i_reg_we;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_p1;
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) mis_p1 <= 1'b0;
    else        mis_p1 <= trap;
  end
  assign o_misaligned = mis_p1;
`else
  assign o_misaligned = 1'b0;
`endif

  assign o_result  = result_p1;
  assign o_rd_addr = rd_p1;
  assign o_reg_we  = vld_p1;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single-cycle ops plus multi-cycle store/load/reset sequences.
module tb_mem_access_unit;

  logic        i_clk = 1'b0;
  logic        i_arst;
  logic [2:0]  i_result_src;
  logic        i_mem_we, i_reg_we;
  logic [2:0]  i_func3;
  logic [63:0] i_pc_plus4, i_pc_target, i_imm_ext, i_alu_result, i_write_data;
  logic [4:0]  i_rd_addr;
  logic        o_mem_req_valid, i_mem_req_ready;
  logic [63:0] o_mem_addr;
  logic        o_mem_we;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wstrb;
  logic        i_mem_rvalid;
  logic [63:0] i_mem_rdata;
  logic        o_stall;
  logic [63:0] o_result;
  logic [4:0]  o_rd_addr;
  logic        o_reg_we, o_misaligned;

  int total = 0;
  int bad   = 0;

  mem_access_unit dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_result_src(i_result_src), .i_mem_we(i_mem_we),
    .i_reg_we(i_reg_we), .i_func3(i_func3), .i_pc_plus4(i_pc_plus4), .i_pc_target(i_pc_target),
    .i_imm_ext(i_imm_ext), .i_alu_result(i_alu_result), .i_write_data(i_write_data),
    .i_rd_addr(i_rd_addr), .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .o_mem_wstrb(o_mem_wstrb), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_stall(o_stall), .o_result(o_result), .o_rd_addr(o_rd_addr), .o_reg_we(o_reg_we),
    .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]  src;
    logic        mem_we;
    logic        reg_we;
    logic [2:0]  f3;
    logic [63:0] alu, imm, pc4, pct, wd;
    logic [4:0]  rd;
    logic        e_req;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata, e_res;
    logic [4:0]  e_rd;
    logic        e_we;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic nop();
    i_result_src = 3'b000; i_mem_we = 1'b0; i_reg_we = 1'b0; i_func3 = 3'b000;
    i_pc_plus4 = '0; i_pc_target = '0; i_imm_ext = '0; i_alu_result = '0; i_write_data = '0;
    i_rd_addr = '0; i_mem_req_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Load issued with ready in cycle 0, rvalid arriving lat cycles after acceptance.
  task automatic do_load(input string nm, input logic [63:0] addr, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [63:0] rdata, input int lat,
                         input logic [63:0] exp);
    int ns;
    ns = 0;
    nop();
    i_result_src = 3'b001; i_func3 = f3; i_alu_result = addr; i_rd_addr = rd;
    i_reg_we = 1'b1; i_mem_req_ready = 1'b1; i_mem_rdata = rdata;
    #1;
    chk({nm, "_req"}, 64'(o_mem_req_valid), 64'd1);
    chk({nm, "_we"}, 64'(o_mem_we), 64'd0);
    chk({nm, "_addr"}, o_mem_addr, {addr[63:3], 3'b000});
    for (int c = 0; c <= lat; c++) begin
      i_mem_rvalid = (c == lat);
      #1;
      if (o_stall) ns++;
      if (c > 0) chk({nm, "_resp_req"}, 64'(o_mem_req_valid), 64'd0);
      tick();
      if (c < lat) chk({nm, "_bubble"}, 64'(o_reg_we), 64'd0);
    end
    chk({nm, "_stall_cycles"}, 64'(ns), 64'(lat));
    chk({nm, "_result"}, o_result, exp);
    chk({nm, "_rd"}, 64'(o_rd_addr), 64'(rd));
    chk({nm, "_regwe"}, 64'(o_reg_we), 64'd1);
    nop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq, nstall;

    tv[0]  = '{3'b000, 1'b0, 1'b1, 3'b011, 64'h1234, 64'h0, 64'h0, 64'h0, 64'h0, 5'd5,
               1'b0, 8'h00, 64'h0, 64'h1234, 5'd5, 1'b1};
    tv[1]  = '{3'b010, 1'b0, 1'b1, 3'b011, 64'h999, 64'h0, 64'h1004, 64'h0, 64'h0, 5'd7,
               1'b0, 8'h00, 64'h0, 64'h1004, 5'd7, 1'b1};
    tv[2]  = '{3'b011, 1'b0, 1'b1, 3'b011, 64'h999, 64'hFFFF_FFFF_FFFF_F000, 64'h0, 64'h0, 64'h0, 5'd1,
               1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_F000, 5'd1, 1'b1};
    tv[3]  = '{3'b100, 1'b0, 1'b1, 3'b011, 64'h999, 64'h0, 64'h0, 64'h8000, 64'h0, 5'd31,
               1'b0, 8'h00, 64'h0, 64'h8000, 5'd31, 1'b1};
    tv[4]  = '{3'b101, 1'b0, 1'b1, 3'b011, 64'h55, 64'h1, 64'h2, 64'h3, 64'h0, 5'd2,
               1'b0, 8'h00, 64'h0, 64'h55, 5'd2, 1'b1};
    tv[5]  = '{3'b111, 1'b0, 1'b0, 3'b011, 64'hDEAD, 64'h1, 64'h2, 64'h3, 64'h0, 5'd3,
               1'b0, 8'h00, 64'h0, 64'hDEAD, 5'd3, 1'b0};
    tv[6]  = '{3'b000, 1'b1, 1'b0, 3'b011, 64'h4000, 64'h0, 64'h0, 64'h0, 64'h1122_3344_5566_7788, 5'd4,
               1'b1, 8'hFF, 64'h1122_3344_5566_7788, 64'hDEAD, 5'd3, 1'b0};
    tv[7]  = '{3'b000, 1'b1, 1'b0, 3'b001, 64'h4006, 64'h0, 64'h0, 64'h0, 64'hBEEF, 5'd4,
               1'b1, 8'hC0, 64'hBEEF_0000_0000_0000, 64'hDEAD, 5'd3, 1'b0};
    tv[8]  = '{3'b000, 1'b1, 1'b0, 3'b010, 64'h4004, 64'h0, 64'h0, 64'h0, 64'hCAFE_BABE, 5'd4,
               1'b1, 8'hF0, 64'hCAFE_BABE_0000_0000, 64'hDEAD, 5'd3, 1'b0};
    tv[9]  = '{3'b000, 1'b1, 1'b0, 3'b000, 64'h4007, 64'h0, 64'h0, 64'h0, 64'h1FF, 5'd4,
               1'b1, 8'h80, 64'hFF00_0000_0000_0000, 64'hDEAD, 5'd3, 1'b0};
    tv[10] = '{3'b001, 1'b1, 1'b1, 3'b000, 64'h4001, 64'h0, 64'h0, 64'h0, 64'h77, 5'd8,
               1'b1, 8'h02, 64'h7700, 64'hDEAD, 5'd3, 1'b0};
    tv[11] = '{3'b000, 1'b0, 1'b1, 3'b011, 64'h42, 64'h0, 64'h0, 64'h0, 64'h0, 5'd6,
               1'b0, 8'h00, 64'h0, 64'h42, 5'd6, 1'b1};

    nop();
    i_arst = 1'b1;
    #12;
    chk("rst_req", 64'(o_mem_req_valid), 64'd0);
    chk("rst_stall", 64'(o_stall), 64'd0);
    chk("rst_result", o_result, 64'd0);
    chk("rst_rd", 64'(o_rd_addr), 64'd0);
    chk("rst_regwe", 64'(o_reg_we), 64'd0);
    chk("rst_mis", 64'(o_misaligned), 64'd0);
    tick();
    i_arst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      i_result_src = tv[i].src; i_mem_we = tv[i].mem_we; i_reg_we = tv[i].reg_we;
      i_func3 = tv[i].f3; i_alu_result = tv[i].alu; i_imm_ext = tv[i].imm;
      i_pc_plus4 = tv[i].pc4; i_pc_target = tv[i].pct; i_write_data = tv[i].wd;
      i_rd_addr = tv[i].rd; i_mem_req_ready = 1'b1; i_mem_rvalid = 1'b0;
      #1;
      chk($sformatf("v%0d_req", i), 64'(o_mem_req_valid), 64'(tv[i].e_req));
      chk($sformatf("v%0d_stall", i), 64'(o_stall), 64'd0);
      if (tv[i].e_req) begin
        chk($sformatf("v%0d_memwe", i), 64'(o_mem_we), 64'd1);
        chk($sformatf("v%0d_addr", i), o_mem_addr, {tv[i].alu[63:3], 3'b000});
        chk($sformatf("v%0d_strb", i), 64'(o_mem_wstrb), 64'(tv[i].e_strb));
        chk($sformatf("v%0d_wdata", i), o_mem_wdata, tv[i].e_wdata);
      end
      tick();
      chk($sformatf("v%0d_result", i), o_result, tv[i].e_res);
      chk($sformatf("v%0d_rd", i), 64'(o_rd_addr), 64'(tv[i].e_rd));
      chk($sformatf("v%0d_regwe", i), 64'(o_reg_we), 64'(tv[i].e_we));
    end

    // Store byte with ready held low for two cycles.
    nop();
    i_mem_we = 1'b1; i_func3 = 3'b000; i_alu_result = 64'h1003; i_write_data = 64'hAB;
    nreq = 0; nstall = 0;
    for (int c = 0; c < 3; c++) begin
      i_mem_req_ready = (c == 2);
      #1;
      if (o_mem_req_valid) nreq++;
      if (o_stall) nstall++;
      chk("stb_addr", o_mem_addr, 64'h1000);
      chk("stb_strb", 64'(o_mem_wstrb), 64'h08);
      chk("stb_wdata", o_mem_wdata, 64'hAB00_0000);
      tick();
      chk("stb_regwe", 64'(o_reg_we), 64'd0);
      chk("stb_result_hold", o_result, 64'h42);
    end
    chk("stb_req_cycles", 64'(nreq), 64'd3);
    chk("stb_stall_cycles", 64'(nstall), 64'd2);
    nop();
    #1;
    chk("stb_after_req", 64'(o_mem_req_valid), 64'd0);
    tick();

    do_load("lh_s", 64'h2006, 3'b001, 5'd9, 64'h8001_0000_0000_0000, 3, 64'hFFFF_FFFF_FFFF_8001);
    do_load("lh_u", 64'h2006, 3'b101, 5'd10, 64'h8001_0000_0000_0000, 3, 64'h8001);
    do_load("lw_min", 64'h2004, 3'b010, 5'd11, 64'h8765_4321_0000_0000, 1, 64'hFFFF_FFFF_8765_4321);
    do_load("lbu", 64'h2001, 3'b100, 5'd13, 64'h0000_0000_0000_F500, 1, 64'hF5);
    do_load("ld", 64'h2008, 3'b011, 5'd14, 64'h0123_4567_89AB_CDEF, 2, 64'h0123_4567_89AB_CDEF);

`ifdef MISALIGN_TRAP_EN
    nop();
    i_result_src = 3'b001; i_func3 = 3'b010; i_alu_result = 64'h3002; i_rd_addr = 5'd12;
    i_reg_we = 1'b1; i_mem_req_ready = 1'b1;
    #1;
    chk("mis_req", 64'(o_mem_req_valid), 64'd0);
    chk("mis_stall", 64'(o_stall), 64'd0);
    tick();
    chk("mis_flag", 64'(o_misaligned), 64'd1);
    chk("mis_regwe", 64'(o_reg_we), 64'd0);
    nop();
    tick();
    chk("mis_flag_clear", 64'(o_misaligned), 64'd0);
`else
    do_load("lw_mis", 64'h3002, 3'b010, 5'd12, 64'h1122_3344_5566_7788, 1, 64'h3344_5566);
    chk("mis_flag_tied", 64'(o_misaligned), 64'd0);
`endif

    // Reset while waiting for load data, then a stray rvalid.
    nop();
    i_result_src = 3'b001; i_func3 = 3'b011; i_alu_result = 64'h5000; i_rd_addr = 5'd20;
    i_reg_we = 1'b1; i_mem_req_ready = 1'b1;
    tick();
    #1;
    i_arst = 1'b1;
    #1;
    chk("rresp_req", 64'(o_mem_req_valid), 64'd0);
    chk("rresp_stall", 64'(o_stall), 64'd0);
    chk("rresp_result", o_result, 64'd0);
    chk("rresp_rd", 64'(o_rd_addr), 64'd0);
    chk("rresp_regwe", 64'(o_reg_we), 64'd0);
    chk("rresp_mis", 64'(o_misaligned), 64'd0);
    nop();
    tick();
    i_arst = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 64'hFFFF_0000_FFFF_0000;
    #1;
    chk("stray_req", 64'(o_mem_req_valid), 64'd0);
    chk("stray_stall", 64'(o_stall), 64'd0);
    tick();
    chk("stray_regwe", 64'(o_reg_we), 64'd0);
    chk("stray_result", o_result, 64'd0);
    nop();

    // IDLE confirmed by a one-cycle ALU op after the reset.
    i_alu_result = 64'h77; i_rd_addr = 5'd21; i_reg_we = 1'b1;
    #1;
    chk("post_rst_stall", 64'(o_stall), 64'd0);
    tick();
    chk("post_rst_result", o_result, 64'h77);
    chk("post_rst_rd", 64'(o_rd_addr), 64'd21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
